// File: rtl/sp_ram_arb.sv
// sp_ram_arb: two-master arbiter in front of a single-port RAM.
//
// Purpose
//   Grants one of two masters per cycle in the same cycle it requests, forwards
//   the winner's access to the RAM, and returns a one-cycle rvalid pulse plus
//   read data to that master in the cycle after the grant. Each port keeps its
//   last read data in a hold register, so rdata stays stable between responses.
//
// Configuration
//   SP_RAM_ARB_RR_EN  defined:   round-robin on conflicts. A priority pointer
//                                flips after every conflict grant.
//                     undefined: fixed priority. Port 0 always wins conflicts
//                                and there is no pointer register.
//
// Ports
//   clk, rstn_i             clock, asynchronous active-low reset
//   pN_req_i/addr/we/be/wdata  master N request fields (N = 0, 1)
//   pN_gnt_o                master N accepted this cycle (combinational)
//   pN_rvalid_o             response for master N's previous grant
//   pN_rdata_o              read data (live on a read response, else held)
//   ram_en/addr/we/be/wdata RAM request; all zero when nobody requests
//   ram_rdata_i             RAM read data, one cycle after an enabled read

module sp_ram_arb #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rstn_i,

   input  logic                    p0_req_i,
   input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
   input  logic                    p0_we_i,
   input  logic [DATA_WIDTH/8-1:0] p0_be_i,
   input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
   output logic                    p0_gnt_o,
   output logic                    p0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p0_rdata_o,

   input  logic                    p1_req_i,
   input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
   input  logic                    p1_we_i,
   input  logic [DATA_WIDTH/8-1:0] p1_be_i,
   input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
   output logic                    p1_gnt_o,
   output logic                    p1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p1_rdata_o,

   output logic                    ram_en_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic                    ram_we_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   logic conflict;
   logic p1_favoured;
   logic gnt0, gnt1;

   // Owner of the access issued last cycle: steers rvalid and read data.
   logic owner_valid_q, owner_valid_d;
   logic owner_port_q,  owner_port_d;
   logic owner_we_q,    owner_we_d;

   logic [DATA_WIDTH-1:0] hold0_q, hold0_d;
   logic [DATA_WIDTH-1:0] hold1_q, hold1_d;

   logic read_resp0, read_resp1;

   assign conflict = p0_req_i & p1_req_i;

`ifdef SP_RAM_ARB_RR_EN
   // prio_q = 0 favours port 0, 1 favours port 1.
   logic prio_q;

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         prio_q <= 1'b0;
      end else if (conflict) begin
         prio_q <= ~prio_q;
      end
   end

   assign p1_favoured = prio_q;
`else
   assign p1_favoured = 1'b0;
`endif

   // Single requester always wins; the pointer only matters on a conflict.
   assign gnt0 = p0_req_i & ~(conflict & p1_favoured);
   assign gnt1 = p1_req_i & ~(conflict & ~p1_favoured);

   assign p0_gnt_o = gnt0;
   assign p1_gnt_o = gnt1;

   always_comb begin
      ram_en_o    = 1'b0;
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_wdata_o = '0;
      if (gnt0) begin
         ram_en_o    = 1'b1;
         ram_addr_o  = p0_addr_i;
         ram_we_o    = p0_we_i;
         ram_be_o    = p0_be_i;
         ram_wdata_o = p0_wdata_i;
      end else if (gnt1) begin
         ram_en_o    = 1'b1;
         ram_addr_o  = p1_addr_i;
         ram_we_o    = p1_we_i;
         ram_be_o    = p1_be_i;
         ram_wdata_o = p1_wdata_i;
      end
   end

   // The loser is not recorded anywhere; it simply keeps requesting.
   always_comb begin
      owner_valid_d = gnt0 | gnt1;
      owner_port_d  = gnt1;
      owner_we_d    = gnt1 ? p1_we_i : (gnt0 ? p0_we_i : 1'b0);
   end

   assign p0_rvalid_o = owner_valid_q & ~owner_port_q;
   assign p1_rvalid_o = owner_valid_q &  owner_port_q;

   assign read_resp0 = p0_rvalid_o & ~owner_we_q;
   assign read_resp1 = p1_rvalid_o & ~owner_we_q;

   // Live RAM data on a read response, otherwise the port's last read data.
   assign p0_rdata_o = read_resp0 ? ram_rdata_i : hold0_q;
   assign p1_rdata_o = read_resp1 ? ram_rdata_i : hold1_q;

   always_comb begin
      hold0_d = hold0_q;
      hold1_d = hold1_q;
      if (read_resp0) hold0_d = ram_rdata_i;
      if (read_resp1) hold1_d = ram_rdata_i;
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         owner_valid_q <= 1'b0;
         owner_port_q  <= 1'b0;
         owner_we_q    <= 1'b0;
         hold0_q       <= '0;
         hold1_q       <= '0;
      end else begin
         owner_valid_q <= owner_valid_d;
         owner_port_q  <= owner_port_d;
         owner_we_q    <= owner_we_d;
         hold0_q       <= hold0_d;
         hold1_q       <= hold1_d;
      end
   end

   logic unused_be_width;
   assign unused_be_width = (BE_WIDTH == 0);

endmodule

// File: tb/tb_sp_ram_arb.sv
// Directed testbench for sp_ram_arb with a small behavioural RAM behind it.
// Expectations adapt to SP_RAM_ARB_RR_EN where arbitration differs.

module tb_sp_ram_arb;

   localparam int unsigned AW = 15;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;

   logic          clk;
   logic          rstn_i;
   logic          p0_req_i, p0_we_i, p0_gnt_o, p0_rvalid_o;
   logic [AW-1:0] p0_addr_i;
   logic [BW-1:0] p0_be_i;
   logic [DW-1:0] p0_wdata_i, p0_rdata_o;
   logic          p1_req_i, p1_we_i, p1_gnt_o, p1_rvalid_o;
   logic [AW-1:0] p1_addr_i;
   logic [BW-1:0] p1_be_i;
   logic [DW-1:0] p1_wdata_i, p1_rdata_o;
   logic          ram_en_o, ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [BW-1:0] ram_be_o;
   logic [DW-1:0] ram_wdata_o, ram_rdata_i;

   int n_checks;
   int n_pass;

   sp_ram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rstn_i      (rstn_i),
      .p0_req_i    (p0_req_i),
      .p0_addr_i   (p0_addr_i),
      .p0_we_i     (p0_we_i),
      .p0_be_i     (p0_be_i),
      .p0_wdata_i  (p0_wdata_i),
      .p0_gnt_o    (p0_gnt_o),
      .p0_rvalid_o (p0_rvalid_o),
      .p0_rdata_o  (p0_rdata_o),
      .p1_req_i    (p1_req_i),
      .p1_addr_i   (p1_addr_i),
      .p1_we_i     (p1_we_i),
      .p1_be_i     (p1_be_i),
      .p1_wdata_i  (p1_wdata_i),
      .p1_gnt_o    (p1_gnt_o),
      .p1_rvalid_o (p1_rvalid_o),
      .p1_rdata_o  (p1_rdata_o),
      .ram_en_o    (ram_en_o),
      .ram_addr_o  (ram_addr_o),
      .ram_we_o    (ram_we_o),
      .ram_be_o    (ram_be_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_rdata_i (ram_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural word RAM, one-cycle read latency.
   logic [DW-1:0] mem [0:63];

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      ram_rdata_i = '0;
   end

   always @(posedge clk) begin
      if (ram_en_o) begin
         if (ram_we_o) begin
            for (int b = 0; b < int'(BW); b++) begin
               if (ram_be_o[b]) mem[ram_addr_o[7:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            end
         end else begin
            ram_rdata_i <= mem[ram_addr_o[7:2]];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive0(input logic req, input logic [AW-1:0] addr, input logic we,
                         input logic [BW-1:0] be, input logic [DW-1:0] wdata);
      p0_req_i = req; p0_addr_i = addr; p0_we_i = we; p0_be_i = be; p0_wdata_i = wdata;
   endtask

   task automatic drive1(input logic req, input logic [AW-1:0] addr, input logic we,
                         input logic [BW-1:0] be, input logic [DW-1:0] wdata);
      p1_req_i = req; p1_addr_i = addr; p1_we_i = we; p1_be_i = be; p1_wdata_i = wdata;
   endtask

   // Advance to the next cycle's drive point (1 time unit after posedge).
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [5:0] seq_req0, seq_req1, seq_gnt0, seq_gnt1;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rstn_i   = 1'b0;
      drive0(1'b0, '0, 1'b0, '0, '0);
      drive1(1'b0, '0, 1'b0, '0, '0);

      // Reset state
      @(negedge clk);
      check("rst_p0_rvalid", {31'b0, p0_rvalid_o}, 32'd0);
      check("rst_p1_rvalid", {31'b0, p1_rvalid_o}, 32'd0);
      check("rst_p0_rdata", p0_rdata_o, 32'd0);
      check("rst_ram_en", {31'b0, ram_en_o}, 32'd0);
      next_cycle();
      rstn_i = 1'b1;
      next_cycle();

      // Write 0x100 then read it back on port 0
      drive0(1'b1, 15'h100, 1'b1, 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      check("wr_p0_gnt", {31'b0, p0_gnt_o}, 32'd1);
      check("wr_ram_addr", {17'b0, ram_addr_o}, 32'h100);
      check("wr_ram_we", {31'b0, ram_we_o}, 32'd1);
      check("wr_ram_wdata", ram_wdata_o, 32'hDEADBEEF);
      next_cycle();
      drive0(1'b1, 15'h100, 1'b0, 4'hF, 32'h0);
      @(negedge clk);
      check("rd_p0_gnt", {31'b0, p0_gnt_o}, 32'd1);
      check("wr_p0_rvalid", {31'b0, p0_rvalid_o}, 32'd1);
      check("wr_resp_p0_rdata_hold", p0_rdata_o, 32'd0);
      next_cycle();
      drive0(1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      check("idle_ram_en", {31'b0, ram_en_o}, 32'd0);
      check("idle_ram_addr", {17'b0, ram_addr_o}, 32'd0);
      check("rd_p0_rvalid", {31'b0, p0_rvalid_o}, 32'd1);
      check("rd_p0_rdata", p0_rdata_o, 32'hDEADBEEF);
      next_cycle();
      @(negedge clk);
      check("post_p0_rvalid", {31'b0, p0_rvalid_o}, 32'd0);
      check("post_p0_rdata_held", p0_rdata_o, 32'hDEADBEEF);
      next_cycle();

      // Byte write over all-ones
      drive0(1'b1, 15'h104, 1'b1, 4'hF, 32'hFFFFFFFF);
      next_cycle();
      drive0(1'b1, 15'h104, 1'b1, 4'h2, 32'h0000AB00);
      @(negedge clk);
      check("bw_ram_be", {28'b0, ram_be_o}, 32'h2);
      next_cycle();
      drive0(1'b1, 15'h104, 1'b0, 4'hF, 32'h0);
      next_cycle();
      drive0(1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      check("bw_rd_rvalid", {31'b0, p0_rvalid_o}, 32'd1);
      check("bw_rd_rdata", p0_rdata_o, 32'hFFFFABFF);
      next_cycle();

      // p1 read data held across p0's write response
      drive0(1'b1, 15'h108, 1'b1, 4'hF, 32'h12345678);
      next_cycle();
      drive0(1'b0, '0, 1'b0, '0, '0);
      drive1(1'b1, 15'h108, 1'b0, 4'hF, 32'h0);
      @(negedge clk);
      check("p1_only_gnt", {31'b0, p1_gnt_o}, 32'd1);
      check("p1_only_ram_addr", {17'b0, ram_addr_o}, 32'h108);
      next_cycle();
      drive1(1'b0, '0, 1'b0, '0, '0);
      drive0(1'b1, 15'h10C, 1'b1, 4'hF, 32'hAAAA5555);
      @(negedge clk);
      check("p1_rd_rvalid", {31'b0, p1_rvalid_o}, 32'd1);
      check("p1_rd_rdata", p1_rdata_o, 32'h12345678);
      check("p1_rd_p0_rvalid", {31'b0, p0_rvalid_o}, 32'd0);
      next_cycle();
      drive0(1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      check("p0_wr_resp_rvalid", {31'b0, p0_rvalid_o}, 32'd1);
      check("p0_wr_resp_p1_rvalid", {31'b0, p1_rvalid_o}, 32'd0);
      check("p0_wr_resp_p1_rdata", p1_rdata_o, 32'h12345678);
      check("p0_wr_resp_p0_rdata", p0_rdata_o, 32'hFFFFABFF);
      next_cycle();

      // Conflicting reads for 4 cycles, then p1 alone, then idle (index 0 first)
      seq_req0 = 6'b001111;
      seq_req1 = 6'b011111;
`ifdef SP_RAM_ARB_RR_EN
      seq_gnt0 = 6'b000101;
      seq_gnt1 = 6'b011010;
`else
      seq_gnt0 = 6'b001111;
      seq_gnt1 = 6'b010000;
`endif
      for (int i = 0; i < 6; i++) begin
         drive0(seq_req0[i], 15'h100, 1'b0, 4'hF, 32'h0);
         drive1(seq_req1[i], 15'h108, 1'b0, 4'hF, 32'h0);
         @(negedge clk);
         check($sformatf("arb_p0_gnt_%0d", i), {31'b0, p0_gnt_o}, {31'b0, seq_gnt0[i]});
         check($sformatf("arb_p1_gnt_%0d", i), {31'b0, p1_gnt_o}, {31'b0, seq_gnt1[i]});
         if (i > 0) begin
            check($sformatf("arb_p0_rvalid_%0d", i), {31'b0, p0_rvalid_o},
                  {31'b0, seq_gnt0[i-1]});
            check($sformatf("arb_p1_rvalid_%0d", i), {31'b0, p1_rvalid_o},
                  {31'b0, seq_gnt1[i-1]});
            if (seq_gnt0[i-1]) check($sformatf("arb_p0_rdata_%0d", i), p0_rdata_o, 32'hDEADBEEF);
            if (seq_gnt1[i-1]) check($sformatf("arb_p1_rdata_%0d", i), p1_rdata_o, 32'h12345678);
         end
         next_cycle();
      end

      // One conflict (p0 wins, pointer moves to p1 under RR), then reset during a p0 grant
      drive0(1'b1, 15'h100, 1'b0, 4'hF, 32'h0);
      drive1(1'b1, 15'h108, 1'b0, 4'hF, 32'h0);
      @(negedge clk);
      check("pre_rst_conflict_p0_gnt", {31'b0, p0_gnt_o}, 32'd1);
      next_cycle();
      drive1(1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      check("rst_cycle_p0_gnt", {31'b0, p0_gnt_o}, 32'd1);
      #1 rstn_i = 1'b0;
      #1;
      check("in_rst_p1_rvalid", {31'b0, p1_rvalid_o}, 32'd0);
      check("in_rst_p0_gnt_comb", {31'b0, p0_gnt_o}, 32'd1);
      check("in_rst_ram_en_comb", {31'b0, ram_en_o}, 32'd1);
      next_cycle();
      drive0(1'b0, '0, 1'b0, '0, '0);
      rstn_i = 1'b1;
      @(negedge clk);
      check("post_rst_p0_rvalid", {31'b0, p0_rvalid_o}, 32'd0);
      check("post_rst_p0_rdata", p0_rdata_o, 32'd0);
      check("post_rst_p1_rdata", p1_rdata_o, 32'd0);
      next_cycle();
      drive0(1'b1, 15'h100, 1'b0, 4'hF, 32'h0);
      drive1(1'b1, 15'h108, 1'b0, 4'hF, 32'h0);
      @(negedge clk);
      check("post_rst_ptr_p0_gnt", {31'b0, p0_gnt_o}, 32'd1);
      check("post_rst_ptr_p1_gnt", {31'b0, p1_gnt_o}, 32'd0);
      next_cycle();
      drive0(1'b0, '0, 1'b0, '0, '0);
      drive1(1'b0, '0, 1'b0, '0, '0);
      next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sp_ram_arb.md
SP_RAM_ARB -- requirements
Module: sp_ram_arb

Interface
REQ-001 ADDR_WIDTH, 15, byte-address width of the RAM behind the arbiter.
REQ-002 DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rstn_i  input  1  reset; asynchronous, active-low.
REQ-005 pN_req_i (N=0,1)  input  1  master N request.
REQ-006 pN_addr_i  input  ADDR_WIDTH  master N byte address.
REQ-007 pN_we_i  input  1  master N write (1) / read (0).
REQ-008 pN_be_i  input  DATA_WIDTH/8  master N byte enables.
REQ-009 pN_wdata_i  input  DATA_WIDTH  master N write data.
REQ-010 pN_gnt_o  output  1  master N request accepted this cycle.
REQ-011 pN_rvalid_o  output  1  response for master N's previously granted request.
REQ-012 pN_rdata_o  output  DATA_WIDTH  read data for master N.
REQ-013 ram_en_o  output  1  RAM enable.
REQ-014 ram_addr_o  output  ADDR_WIDTH  RAM byte address.
REQ-015 ram_we_o  output  1  RAM write enable.
REQ-016 ram_be_o  output  DATA_WIDTH/8  RAM byte enables.
REQ-017 ram_wdata_o  output  DATA_WIDTH  RAM write data.
REQ-018 ram_rdata_i  input  DATA_WIDTH  RAM read data; valid one cycle after an enabled read.

Function
REQ-019 Grant SHALL be combinational, in the same cycle as req; pN_gnt_o=1 only when pN_req_i=1.
REQ-020 Exactly one port SHALL be granted when any req is high; only one requester -> it wins; both -> arbitration policy (REQ-029).
REQ-021 ram_en_o SHALL equal p0_req_i|p1_req_i; ram_addr/we/be/wdata SHALL be the winner's fields unchanged; with no request, all ram_* outputs SHALL be 0.
REQ-022 pN_rvalid_o SHALL pulse high for exactly one cycle, the cycle after port N was granted, for reads and writes alike.
REQ-023 An owner register SHALL record the granted port and its we; it steers rvalid and read data in the following cycle.
REQ-024 On a read response, pN_rdata_o SHALL equal ram_rdata_i in the rvalid cycle, and a per-port hold register SHALL capture it at that cycle's end.
REQ-025 Outside read-response cycles (idle, other port's response, write response), pN_rdata_o SHALL present that port's hold register.
REQ-026 A port SHALL be grantable every cycle; back-to-back grants produce back-to-back rvalids (throughput 1 access/cycle).
REQ-027 Write at cycle t then read same address at t+1 SHALL return the written data (RAM ordering preserved, no reordering).
REQ-028 The losing port's request SHALL NOT be latched; it stays pending on its own inputs until granted.
REQ-029 Policy: with SP_RAM_ARB_RR_EN, priority pointer selects the conflict winner and moves to the other port after every conflict grant; pointer unchanged on non-conflict grants.

Reset
REQ-030 While rstn_i=0: pN_rvalid_o=0, owner cleared, hold registers=0, priority pointer=port 0.
REQ-031 A grant issued in the cycle reset asserts SHALL produce no rvalid after reset release.
REQ-032 pN_gnt_o and ram_* remain combinational from req during reset; no state advances.

Configuration
REQ-033 Macro SP_RAM_ARB_RR_EN defined: round-robin per REQ-029; undefined: fixed priority, port 0 always wins conflicts and no pointer register exists.

Verification
REQ-034 p0 write 0x100=0xDEADBEEF be=0xF, next cycle p0 read 0x100 -> gnt same cycles, rvalid t+1/t+2, p0_rdata_o=0xDEADBEEF at t+2 and held after.
REQ-035 Both ports request reads for 4 cycles with RR_EN -> gnts alternate p0,p1,p0,p1; each rvalid exactly one cycle after its gnt; without RR_EN -> p0 granted all 4, p1 none.
REQ-036 p1 read returns 0x12345678, then p0 write -> p1_rdata_o stays 0x12345678 during p0's write rvalid.
REQ-037 Byte write be=0x2 data 0x0000AB00 over 0xFFFFFFFF, then read -> 0xFFFFABFF.
REQ-038 rstn_i asserted in cycle of p0 read grant -> no p0_rvalid_o after release; rdata outputs 0; pointer favours p0.
